// File: rtl/grf_pkg.sv
// Shared defaults and the write-log record type for the scoreboarded register file.
package grf_pkg;

    localparam int unsigned GRF_DATA_W = 32;
    localparam int unsigned GRF_ADDR_W = 5;
    localparam int unsigned GRF_PC_W   = 32;

    typedef struct packed {
        logic [GRF_PC_W-1:0]   pc;
        logic [GRF_ADDR_W-1:0] rd;
        logic [GRF_DATA_W-1:0] data;
    } grf_log_t;

endpackage

// File: rtl/grf_rport.sv
// One combinational read port: array lookup with same-cycle write bypass and pending flag.
module grf_rport
    import grf_pkg::*;
#(
    parameter int unsigned DATA_W = GRF_DATA_W,
    parameter int unsigned ADDR_W = GRF_ADDR_W,
    parameter int unsigned DEPTH  = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
    input  logic [DEPTH-1:0]              pend,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             wt,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             data,
    output logic                          pending
);

    logic zero;
    logic hit;

    always_comb begin
        zero    = (addr == '0);
        hit     = we && (wt == addr) && !zero;
        data    = '0;
        pending = 1'b0;
        if (!zero) begin
            data    = hit ? wdata : regs[addr];
            pending = pend[addr] && !hit;
        end
    end

endmodule

// File: rtl/grf_scb.sv
// Register file with per-register pending scoreboard, multi-port bypassed reads
// and a registered write-log record.
module grf_scb
    import grf_pkg::*;
#(
    parameter int unsigned DATA_W = GRF_DATA_W,
    parameter int unsigned ADDR_W = GRF_ADDR_W,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rpend,
    input  logic                     WE,
    input  logic [ADDR_W-1:0]        wt,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [31:0]              wPc,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_rd,
    output logic                     iss_ready,
    output logic                     log_valid,
    output logic [31:0]              log_pc,
    output logic [ADDR_W-1:0]        log_rd,
    output logic [DATA_W-1:0]        log_data
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             pend;
    logic                         wr_commit;
    logic                         iss_set;

    always_comb begin
        wr_commit = WE && (wt != '0);
        iss_ready = iss_en && ((iss_rd == '0) || !pend[iss_rd] || (WE && (wt == iss_rd)));
        iss_set   = iss_ready && (iss_rd != '0);
    end

    // Issue set is applied after the write clear so a same-cycle issue keeps the register pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem       <= '0;
            pend      <= '0;
            log_valid <= 1'b0;
            log_pc    <= '0;
            log_rd    <= '0;
            log_data  <= '0;
        end else begin
            log_valid <= wr_commit;
            if (wr_commit) begin
                mem[wt]  <= wdata;
                pend[wt] <= 1'b0;
                log_pc   <= wPc;
                log_rd   <= wt;
                log_data <= wdata;
            end
            if (iss_set) begin
                pend[iss_rd] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rport
        grf_rport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_rport (
            .addr    (rd[i*ADDR_W +: ADDR_W]),
            .regs    (mem),
            .pend    (pend),
            .we      (WE),
            .wt      (wt),
            .wdata   (wdata),
            .data    (rdata[i*DATA_W +: DATA_W]),
            .pending (rpend[i])
        );
    end

endmodule

// File: tb/tb_grf_scb.sv
// Directed self-checking bench for grf_scb at default parameters.
module tb_grf_scb;
    import grf_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*AW-1:0]  rd;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rpend;
    logic              WE;
    logic [AW-1:0]     wt;
    logic [DW-1:0]     wdata;
    logic [31:0]       wPc;
    logic              iss_en;
    logic [AW-1:0]     iss_rd;
    logic              iss_ready;
    logic              log_valid;
    logic [31:0]       log_pc;
    logic [AW-1:0]     log_rd;
    logic [DW-1:0]     log_data;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    grf_log_t    exp_log;

    grf_scb #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd        (rd),
        .rdata     (rdata),
        .rpend     (rpend),
        .WE        (WE),
        .wt        (wt),
        .wdata     (wdata),
        .wPc       (wPc),
        .iss_en    (iss_en),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .log_valid (log_valid),
        .log_pc    (log_pc),
        .log_rd    (log_rd),
        .log_data  (log_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd = {a1, a0};
    endtask

    initial begin
        reset = 1'b1; rd = '0; WE = 1'b0; wt = '0; wdata = '0; wPc = '0;
        iss_en = 1'b0; iss_rd = '0;
        tick();
        tick();
        reset = 1'b0;

        // Post-reset contents
        for (int r = 1; r < 32; r++) begin
            set_rd(AW'(r), AW'(r));
            #1;
            check("rst_rdata0", rdata[DW-1:0], 64'h0);
            check("rst_rdata1", rdata[2*DW-1:DW], 64'h0);
            check("rst_rpend", rpend, 64'h0);
            check("rst_logv", log_valid, 64'h0);
        end

        // Write to r0 ignored, no log
        WE = 1'b1; wt = 5'd0; wdata = 32'd32; wPc = 32'd4; set_rd(5'd0, 5'd0);
        #1;
        check("r0_bypass", rdata[DW-1:0], 64'h0);
        tick();
        WE = 1'b0;
        #1;
        check("r0_after", rdata[DW-1:0], 64'h0);
        check("r0_nolog", log_valid, 64'h0);

        // Bypass and log record
        WE = 1'b1; wt = 5'd3; wdata = 32'h20; wPc = 32'h3008; set_rd(5'd4, 5'd3);
        #1;
        check("wr3_bypass", rdata[2*DW-1:DW], 64'h20);
        check("wr3_port0", rdata[DW-1:0], 64'h0);
        tick();
        WE = 1'b0; wdata = 32'hDEAD; wPc = 32'h1;
        #1;
        exp_log = '{pc: 32'h3008, rd: 5'd3, data: 32'h20};
        check("log_valid", log_valid, 64'h1);
        check("log_pc", log_pc, 64'(exp_log.pc));
        check("log_rd", log_rd, 64'(exp_log.rd));
        check("log_data", log_data, 64'(exp_log.data));
        check("wr3_array", rdata[2*DW-1:DW], 64'h20);
        tick();
        check("log_drop", log_valid, 64'h0);
        check("log_pc_hold", log_pc, 64'h3008);

        // Issue, WAW stall, write clears
        iss_en = 1'b1; iss_rd = 5'd5;
        #1;
        check("iss5_ready", iss_ready, 64'h1);
        tick();
        iss_en = 1'b0; set_rd(5'd5, 5'd0);
        #1;
        check("pend5", rpend[0], 64'h1);
        check("pend_r0", rpend[1], 64'h0);
        iss_en = 1'b1;
        #1;
        check("iss5_waw", iss_ready, 64'h0);
        tick();
        iss_en = 1'b0;
        #1;
        check("pend5_hold", rpend[0], 64'h1);
        WE = 1'b1; wt = 5'd5; wdata = 32'd7;
        #1;
        check("pend5_clr_now", rpend[0], 64'h0);
        check("rd5_bypass", rdata[DW-1:0], 64'h7);
        tick();
        WE = 1'b0;
        #1;
        check("pend5_clr", rpend[0], 64'h0);
        check("rd5_array", rdata[DW-1:0], 64'h7);

        // Issue to r0 accepted without effect
        iss_en = 1'b1; iss_rd = 5'd0;
        #1;
        check("iss0_ready", iss_ready, 64'h1);
        tick();
        iss_en = 1'b0; set_rd(5'd0, 5'd0);
        #1;
        check("iss0_nopend", rpend, 64'h0);

        // Same-cycle issue and write: set wins
        iss_en = 1'b1; iss_rd = 5'd6; WE = 1'b1; wt = 5'd6; wdata = 32'd9;
        tick();
        iss_en = 1'b0; WE = 1'b0; set_rd(5'd0, 5'd6);
        #1;
        check("r6_data", rdata[2*DW-1:DW], 64'h9);
        check("r6_pend", rpend[1], 64'h1);
        iss_en = 1'b1; iss_rd = 5'd6;
        #1;
        check("iss6_stall", iss_ready, 64'h0);
        WE = 1'b1; wt = 5'd6; wdata = 32'd10;
        #1;
        check("iss6_wr_ok", iss_ready, 64'h1);
        tick();
        iss_en = 1'b0; WE = 1'b0;
        #1;
        check("r6_data2", rdata[2*DW-1:DW], 64'hA);
        check("r6_pend2", rpend[1], 64'h1);

        // Reset dominates write and issue
        WE = 1'b1; wt = 5'd7; wdata = 32'h55;
        tick();
        WE = 1'b0; set_rd(5'd7, 5'd8);
        #1;
        check("r7_pre", rdata[DW-1:0], 64'h55);
        reset = 1'b1; WE = 1'b1; wt = 5'd7; wdata = 32'hAA; iss_en = 1'b1; iss_rd = 5'd8;
        #1;
        check("rst_iss_comb", iss_ready, 64'h1);
        tick();
        reset = 1'b0; WE = 1'b0; iss_en = 1'b0;
        #1;
        check("r7_reset", rdata[DW-1:0], 64'h0);
        check("r8_nopend", rpend[1], 64'h0);
        check("rst_logv2", log_valid, 64'h0);
        check("rst_logpc", log_pc, 64'h0);
        check("rst_logdata", log_data, 64'h0);
        set_rd(5'd6, 5'd3);
        #1;
        check("r6_reset", rdata[DW-1:0], 64'h0);
        check("r6_pend_rst", rpend[0], 64'h0);
        check("r3_reset", rdata[2*DW-1:DW], 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
